chebyshev_saturation: RTL and testbench

CHEBYSHEV_SATURATION -- requirements
Module: chebyshev_saturation

---
 rtl/chebyshev_saturation.sv | 142 ++++++++++++++
 tb/tb_chebyshev_saturation.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/chebyshev_saturation.sv
// -----------------------------------------------------------------------------
// chebyshev_saturation
//
// Narrows a signed fixed-point sample from Q(I_BITS).F to
// Q(BOUNDARY_BIT_POSITION).F by dropping D = I_BITS - BOUNDARY_BIT_POSITION
// integer MSBs. Any sample that does not fit is clipped to the largest
// positive or most negative output code. Fractional bits pass through
// unchanged and no rounding is applied. The latency is one clock, and every
// output is registered.
//
// Parameters
//   WL                     input word length (two's complement)
//   I_BITS                 integer bits of data_in, sign included
//   BOUNDARY_BIT_POSITION  integer bits kept in data_out, sign included
//   O_BITS (derived)       WL - (I_BITS - BOUNDARY_BIT_POSITION)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset; clears every output register
//   in_valid   qualifies data_in
//   data_in    signed sample, WL bits
//   out_valid  qualifies data_out / sat_flag, one cycle after in_valid
//   data_out   signed saturated sample, O_BITS bits; holds while idle
//   sat_flag   the sample currently on data_out was clipped
//
// Optional status block, enabled by defining CHEBYSHEV_SATURATION_STATUS_EN
//   sat_clr    synchronous clear of sat_sticky and sat_count; it wins over a
//              clip counted in the same cycle
//   sat_sticky set by any clipped valid sample
//   sat_count  16-bit count of clipped valid samples; saturates at 0xFFFF
// -----------------------------------------------------------------------------
module chebyshev_saturation #(
  parameter int WL                    = 12,
  parameter int I_BITS                = 6,
  parameter int BOUNDARY_BIT_POSITION = 3
) (
  input  logic                                                      clk,
  input  logic                                                      rst_n,
  input  logic                                                      in_valid,
  input  logic signed [WL-1:0]                                      data_in,
`ifdef CHEBYSHEV_SATURATION_STATUS_EN
  input  logic                                                      sat_clr,
  output logic                                                      sat_sticky,
  output logic        [15:0]                                        sat_count,
`endif
  output logic                                                      out_valid,
  output logic signed [WL-(I_BITS-BOUNDARY_BIT_POSITION)-1:0]       data_out,
  output logic                                                      sat_flag
);

  localparam int D      = I_BITS - BOUNDARY_BIT_POSITION;
  localparam int O_BITS = WL - D;

  // Reject configurations that would give an empty or negative output word.
  generate
    if (!((BOUNDARY_BIT_POSITION >= 1) && (BOUNDARY_BIT_POSITION < I_BITS) &&
          (I_BITS <= WL))) begin : g_bad_params
      $error("chebyshev_saturation: need 1 <= BOUNDARY_BIT_POSITION < I_BITS <= WL");
    end
  endgenerate

  // The sample fits only when the D dropped MSBs and the new sign bit all
  // agree. That makes D+1 identical bits.
  function automatic logic is_overflow(input logic signed [WL-1:0] d);
    logic [D:0] head;
    head = d[WL-1:O_BITS-1];
    return !((head == '0) || (head == '1));
  endfunction

  // Clip to the extreme codes. In-range samples keep their low O_BITS bits.
  function automatic logic signed [O_BITS-1:0] saturate(input logic signed [WL-1:0] d);
    logic signed [O_BITS-1:0] r;
    if (!is_overflow(d)) begin
      r = d[O_BITS-1:0];
    end else if (d[WL-1] == 1'b0) begin
      r = {1'b0, {(O_BITS-1){1'b1}}};
    end else begin
      r = {1'b1, {(O_BITS-1){1'b0}}};
    end
    return r;
  endfunction

  // ---- stage p0: combinational overflow detection and clipping ----
  logic                     ovf_p0;
  logic signed [O_BITS-1:0] data_p0;
  logic                     vld_p0;

  always_comb begin
    vld_p0  = in_valid;
    ovf_p0  = is_overflow(data_in);
    data_p0 = saturate(data_in);
  end

  // ---- stage p1: output registers ----
  logic                     vld_p1;
  logic signed [O_BITS-1:0] data_p1;
  logic                     sat_p1;

  // Data and flag load only with a valid sample, so they hold while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      sat_p1  <= 1'b0;
    end else begin
      vld_p1 <= vld_p0;
      if (vld_p0) begin
        data_p1 <= data_p0;
        sat_p1  <= ovf_p0;
      end
    end
  end

  assign out_valid = vld_p1;
  assign data_out  = data_p1;
  assign sat_flag  = sat_p1;

`ifdef CHEBYSHEV_SATURATION_STATUS_EN
  // ---- status: sticky clip indicator and saturating clip counter ----
  logic        sticky_p1;
  logic [15:0] count_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_p1 <= 1'b0;
      count_p1  <= '0;
    end else if (sat_clr) begin
      sticky_p1 <= 1'b0;
      count_p1  <= '0;
    end else if (vld_p0 && ovf_p0) begin
      sticky_p1 <= 1'b1;
      if (count_p1 != 16'hFFFF) begin
        count_p1 <= count_p1 + 16'd1;
      end
    end
  end

  assign sat_sticky = sticky_p1;
  assign sat_count  = count_p1;
`endif

endmodule

// File: tb/tb_chebyshev_saturation.sv
module tb_chebyshev_saturation;

  localparam int WL     = 12;
  localparam int I_BITS = 6;
  localparam int BBP    = 3;
  localparam int O_BITS = WL - (I_BITS - BBP);

  typedef struct packed {
    logic [O_BITS-1:0] d;
    logic              f;
  } exp_t;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     in_valid = 1'b0;
  logic signed [WL-1:0]     data_in = '0;
  logic                     out_valid;
  logic signed [O_BITS-1:0] data_out;
  logic                     sat_flag;
`ifdef CHEBYSHEV_SATURATION_STATUS_EN
  logic                     sat_clr = 1'b0;
  logic                     sat_sticky;
  logic [15:0]              sat_count;
`endif

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];
  exp_t last_exp;

  chebyshev_saturation #(
    .WL(WL), .I_BITS(I_BITS), .BOUNDARY_BIT_POSITION(BBP)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .data_in(data_in),
`ifdef CHEBYSHEV_SATURATION_STATUS_EN
    .sat_clr(sat_clr),
    .sat_sticky(sat_sticky),
    .sat_count(sat_count),
`endif
    .out_valid(out_valid),
    .data_out(data_out),
    .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  // Arithmetic reference: clamp the integer value of the input to the
  // output range.
  function automatic exp_t model(input logic [WL-1:0] d);
    int   v;
    int   maxv;
    int   minv;
    logic [31:0] vb;
    exp_t e;
    v    = int'($signed(d));
    maxv = (1 << (O_BITS - 1)) - 1;
    minv = -(1 << (O_BITS - 1));
    if (v > maxv) begin
      vb = maxv; e.f = 1'b1;
    end else if (v < minv) begin
      vb = minv; e.f = 1'b1;
    end else begin
      vb = v; e.f = 1'b0;
    end
    e.d = vb[O_BITS-1:0];
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Compare the outputs #1 after the edge that follows a driven step.
  task automatic compare_out(input logic v);
    exp_t e;
    check("out_valid", {31'd0, out_valid}, {31'd0, v});
    if (v) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL scoreboard_empty observed=%0h expected=none", data_out);
      end else begin
        e = sb.pop_front();
        check("data_out", {23'd0, data_out}, {23'd0, e.d});
        check("sat_flag", {31'd0, sat_flag}, {31'd0, e.f});
        last_exp = e;
      end
    end else begin
      check("hold_data", {23'd0, data_out}, {23'd0, last_exp.d});
      check("hold_flag", {31'd0, sat_flag}, {31'd0, last_exp.f});
    end
  endtask

  task automatic step_lit(input logic [WL-1:0] d, input logic [O_BITS-1:0] ed, input logic ef);
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1;
    data_in  = d;
    e.d = ed; e.f = ef;
    sb.push_back(e);
    @(posedge clk); #1;
    compare_out(1'b1);
  endtask

  task automatic step_model(input logic v, input logic [WL-1:0] d);
    @(negedge clk);
    in_valid = v;
    data_in  = d;
    if (v) sb.push_back(model(d));
    @(posedge clk); #1;
    compare_out(v);
  endtask

  initial begin
    last_exp = '0;
    // Reset state while rst_n is held low.
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_data_out",  {23'd0, data_out},  32'd0);
    check("rst_sat_flag",  {31'd0, sat_flag},  32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors and boundaries.
    step_lit(12'b111100_000000, 9'b100000000, 1'b0);  // -4.0, exact min
    step_lit(12'b001000_000001, 9'b011111111, 1'b1);  // +8.016 clipped
    step_lit(12'b000001_110110, 9'b001110110, 1'b0);  // in range
    step_lit(12'b000100_000011, 9'b011111111, 1'b1);  // back-to-back clips
    step_lit(12'b000100_000000, 9'b011111111, 1'b1);  // +4.0 clipped
    step_lit(12'b000011_111111, 9'b011111111, 1'b0);  // exact max
    step_lit(12'b111011_111111, 9'b100000000, 1'b1);  // just below min
    step_model(1'b0, 12'h5A5);                        // idle: hold
    step_model(1'b0, 12'h000);
    step_lit(12'b101000_000000, 9'b100000000, 1'b1);  // -24.0 clipped

    // Asynchronous reset mid-stream discards the in-flight sample.
    @(negedge clk);
    in_valid = 1'b1;
    data_in  = 12'b010000_000000;
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", {31'd0, out_valid}, 32'd0);
    check("async_rst_data",  {23'd0, data_out},  32'd0);
    check("async_rst_flag",  {31'd0, sat_flag},  32'd0);
    @(posedge clk); #1;
    check("rst_hold_valid", {31'd0, out_valid}, 32'd0);
    check("rst_hold_data",  {23'd0, data_out},  32'd0);
    sb.delete();
    last_exp = '0;
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;

    // The first sample after reset appears one cycle later.
    step_lit(12'b000000_101010, 9'b000101010, 1'b0);

    // Random traffic against the arithmetic reference.
    for (int i = 0; i < 60; i++) begin
      step_model(($urandom_range(0, 3) != 0), WL'($urandom));
    end

`ifdef CHEBYSHEV_SATURATION_STATUS_EN
    @(negedge clk);
    in_valid = 1'b0;
    sat_clr  = 1'b1;
    @(negedge clk);
    sat_clr  = 1'b0;
    step_lit(12'b011000_000000, 9'b011111111, 1'b1);
    step_lit(12'b100000_000000, 9'b100000000, 1'b1);
    step_lit(12'b000000_000001, 9'b000000001, 1'b0);
    step_lit(12'b000111_000000, 9'b011111111, 1'b1);
    check("sat_count_3", {16'd0, sat_count}, 32'd3);
    check("sat_sticky_1", {31'd0, sat_sticky}, 32'd1);
    // A clear in the same cycle as a clip wins.
    @(negedge clk);
    sat_clr  = 1'b1;
    in_valid = 1'b1;
    data_in  = 12'b011000_000000;
    @(posedge clk); #1;
    check("sat_count_clr", {16'd0, sat_count}, 32'd0);
    check("sat_sticky_clr", {31'd0, sat_sticky}, 32'd0);
    @(negedge clk);
    sat_clr  = 1'b0;
`endif

    @(negedge clk);
    in_valid = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
